fft_frame_loader: RTL and testbench

//  Write-side producer for the ping-pong FFT sample memory (dual_RAM, 512-pt FFT).

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_frame_loader_if.sv | 33 +++
 rtl/fft_frame_loader_bank.sv | 71 +++++++
 rtl/fft_frame_loader.sv | 108 ++++++++++
 tb/tb_fft_frame_loader.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT sample-memory path: frame geometry, complex sample
// layout and the bit-reversed addressing used by both the writer and the reader.
package fft_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int M         = 9;
    localparam int N         = 1 << M;

    typedef struct packed {
        logic signed [BIT_WIDTH-1:0] re;
        logic signed [BIT_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } ld_state_t;

    function automatic logic [M-1:0] bitrev(input logic [M-1:0] idx);
        logic [M-1:0] r;
        for (int i = 0; i < M; i++) begin
            r[i] = idx[M-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Sample-in / RAM-write / FFT-handshake bundle of the frame loader.
// master is the loader side, slave is the sample source + RAM + FFT side.
interface fft_frame_loader_if
    import fft_pkg::*;
#(
    parameter int DROP_W = 16
);

    logic signed [BIT_WIDTH-1:0] sample_in;
    logic                        sample_valid;
    logic                        fft_done;
    logic                        wr_en;
    logic                        wr_bank;
    logic [M-1:0]                wr_addr;
    cplx_t                       wr_data;
    logic                        frame_ready;
    logic                        frame_bank;
    logic                        overflow;
    logic [DROP_W-1:0]           drop_count;

    modport master (
        input  sample_in, sample_valid, fft_done,
        output wr_en, wr_bank, wr_addr, wr_data,
        output frame_ready, frame_bank, overflow, drop_count
    );

    modport slave (
        output sample_in, sample_valid, fft_done,
        input  wr_en, wr_bank, wr_addr, wr_data,
        input  frame_ready, frame_bank, overflow, drop_count
    );

endinterface

// File: rtl/fft_frame_loader_bank.sv
// Ping-pong bank bookkeeping: which banks hold full frames, which bank fills next,
// and which full bank is oldest. Releases from the FFT are applied before completions.
module fft_frame_loader_bank (
    input  logic clk,
    input  logic reset_n,
    input  logic fft_done,
    input  logic complete,
    input  logic in_stall,
    output logic released,
    output logic go_stall,
    output logic fill_bank,
    output logic frame_bank,
    output logic frame_ready
);

    logic [1:0] full_q, full_d, full_rel;
    logic       fill_bank_q, fill_bank_d;
    logic       frame_bank_q, frame_bank_d;
    logic       frame_ready_q, frame_ready_d;

    always_comb begin
        released     = fft_done && full_q[frame_bank_q];
        go_stall     = 1'b0;
        full_rel     = full_q;
        fill_bank_d  = fill_bank_q;
        frame_bank_d = frame_bank_q;

        if (released) begin
            full_rel[frame_bank_q] = 1'b0;
            if (full_q[~frame_bank_q]) begin
                frame_bank_d = ~frame_bank_q;
            end
            // Leaving STALL: the freed bank is the only place left to fill.
            if (in_stall) begin
                fill_bank_d = frame_bank_q;
            end
        end

        full_d = full_rel;
        if (complete) begin
            full_d[fill_bank_q] = 1'b1;
            if (full_rel[~fill_bank_q]) begin
                go_stall = 1'b1;
            end else begin
                fill_bank_d  = ~fill_bank_q;
                frame_bank_d = fill_bank_q;
            end
        end

        frame_ready_d = |full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q        <= 2'b00;
            fill_bank_q   <= 1'b0;
            frame_bank_q  <= 1'b0;
            frame_ready_q <= 1'b0;
        end else begin
            full_q        <= full_d;
            fill_bank_q   <= fill_bank_d;
            frame_bank_q  <= frame_bank_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    assign fill_bank   = fill_bank_q;
    assign frame_bank  = frame_bank_q;
    assign frame_ready = frame_ready_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Write-side producer for the ping-pong FFT sample RAM: stores real samples as {Re, 0}
// at bit-reversed addresses, hands full banks to the FFT and counts dropped samples.
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int DROP_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    fft_frame_loader_if.master  bus
);

    ld_state_t         state_q, state_d;
    logic [M-1:0]      n_q, n_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_bank_q, wr_bank_d;
    logic [M-1:0]      wr_addr_q, wr_addr_d;
    cplx_t             wr_data_q, wr_data_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;

    logic accept, drop, complete;
    logic released, go_stall, fill_bank;

    fft_frame_loader_bank u_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .fft_done    (bus.fft_done),
        .complete    (complete),
        .in_stall    (state_q == STALL),
        .released    (released),
        .go_stall    (go_stall),
        .fill_bank   (fill_bank),
        .frame_bank  (bus.frame_bank),
        .frame_ready (bus.frame_ready)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (go_stall) state_d = STALL;
            STALL:   if (released) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // A sample arriving in the same cycle as the STALL release is still dropped.
    always_comb begin
        accept   = bus.sample_valid && (state_q == FILL);
        drop     = bus.sample_valid && (state_q == STALL);
        complete = accept && (n_q == '1);
    end

    always_comb begin
        wr_en_d      = accept;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        n_d          = n_q;
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (accept) begin
            wr_bank_d = fill_bank;
            wr_addr_d = bitrev(n_q);
            wr_data_d = cplx_t'{re: bus.sample_in, im: '0};
            n_d       = n_q + M'(1);
        end
        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q          <= '0;
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            n_q          <= n_d;
            wr_en_q      <= wr_en_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: scoreboarded RAM writes plus frame/overflow corner cases.
module tb_fft_frame_loader;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fft_frame_loader_if #(.DROP_W(16)) bus ();
    fft_frame_loader_if #(.DROP_W(4))  bus4 ();

    fft_frame_loader #(.DROP_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    fft_frame_loader #(.DROP_W(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    typedef struct {
        logic        bank;
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic signed [15:0] val;
        logic [8:0]         addr;
        logic [31:0]        data;
    } vec_t;

    wr_t  sb[$];
    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] rev9(input int k);
        int r = 0;
        for (int i = 0; i < 9; i++) r = (r << 1) | ((k >> i) & 1);
        return 9'(r);
    endfunction

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: bank %0d addr %0d, none expected", bus.wr_bank, bus.wr_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_bank", 32'(bus.wr_bank), 32'(e.bank));
                chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("wr_data", 32'(bus.wr_data), e.data);
            end
        end
    end

    // Inputs change 1 time unit after a rising edge and are held for one cycle.
    task automatic drive(input logic signed [15:0] val, input logic vld, input logic done);
        bus.sample_in    = val;
        bus.sample_valid = vld;
        bus.fft_done     = done;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        bus.fft_done     = 1'b0;
    endtask

    task automatic send_exp(input logic signed [15:0] val, input logic bank,
                            input logic [8:0] addr, input logic done);
        wr_t e;
        e.bank = bank;
        e.addr = addr;
        e.data = {val, 16'h0000};
        sb.push_back(e);
        drive(val, 1'b1, done);
    endtask

    task automatic fill_frame(input int first_k, input logic bank, input logic done_last);
        for (int k = first_k; k < 512; k++) begin
            send_exp(16'(k), bank, rev9(k), done_last && (k == 511));
        end
    endtask

    task automatic drive4(input int count);
        for (int i = 0; i < count; i++) begin
            bus4.sample_in    = 16'(i);
            bus4.sample_valid = 1'b1;
            @(posedge clk);
            #1;
            bus4.sample_valid = 1'b0;
        end
    endtask

    initial begin
        bus.sample_in = '0;  bus.sample_valid = 1'b0;  bus.fft_done = 1'b0;
        bus4.sample_in = '0; bus4.sample_valid = 1'b0; bus4.fft_done = 1'b0;

        tbl[0] = '{16'sd0, 9'd0,   32'h0000_0000};
        tbl[1] = '{16'sd1, 9'd256, 32'h0001_0000};
        tbl[2] = '{16'sd2, 9'd128, 32'h0002_0000};
        tbl[3] = '{16'sd3, 9'd384, 32'h0003_0000};
        tbl[4] = '{16'sd4, 9'd64,  32'h0004_0000};
        tbl[5] = '{16'sd5, 9'd320, 32'h0005_0000};
        tbl[6] = '{16'sd6, 9'd192, 32'h0006_0000};
        tbl[7] = '{16'sd7, 9'd448, 32'h0007_0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_frame_ready", 32'(bus.frame_ready), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Partial frame, then reset mid-frame.
        for (int k = 0; k < 5; k++) send_exp(-16'sd100 - 16'(k), 1'b0, rev9(k), 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("midrst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("midrst_wr_bank", 32'(bus.wr_bank), 32'd0);
        chk("midrst_frame_bank", 32'(bus.frame_bank), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // fft_done with nothing full must be ignored.
        drive(16'sd0, 1'b0, 1'b1);
        chk("idle_done_ready", 32'(bus.frame_ready), 32'd0);

        // Frame into bank 0: first entries from the table, rest generated.
        for (int i = 0; i < 8; i++) begin
            wr_t e;
            e.bank = 1'b0;
            e.addr = tbl[i].addr;
            e.data = tbl[i].data;
            sb.push_back(e);
            drive(tbl[i].val, 1'b1, 1'b0);
        end
        fill_frame(8, 1'b0, 1'b0);
        chk("f0_frame_ready", 32'(bus.frame_ready), 32'd1);
        chk("f0_frame_bank", 32'(bus.frame_bank), 32'd0);

        // Bank 1 with negative samples, then both full.
        for (int k = 0; k < 512; k++) send_exp(16'(k) - 16'sd32768, 1'b1, rev9(k), 1'b0);
        chk("f1_frame_ready", 32'(bus.frame_ready), 32'd1);
        chk("f1_frame_bank", 32'(bus.frame_bank), 32'd0);
        chk("f1_overflow", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < 10; i++) drive(16'sd77, 1'b1, 1'b0);
        chk("stall_overflow", 32'(bus.overflow), 32'd1);
        chk("stall_drop_count", 32'(bus.drop_count), 32'd10);

        // Release bank 0 from STALL.
        drive(16'sd0, 1'b0, 1'b1);
        chk("rel_frame_bank", 32'(bus.frame_bank), 32'd1);
        chk("rel_frame_ready", 32'(bus.frame_ready), 32'd1);
        send_exp(16'sd1234, 1'b0, 9'd0, 1'b0);
        chk("rel_drop_count", 32'(bus.drop_count), 32'd10);

        // Finish bank 0 while bank 1 is released the same cycle.
        fill_frame(1, 1'b0, 1'b1);
        chk("coll0_frame_bank", 32'(bus.frame_bank), 32'd0);
        chk("coll0_frame_ready", 32'(bus.frame_ready), 32'd1);

        // Finish bank 1 while bank 0 is released the same cycle: no STALL.
        fill_frame(0, 1'b1, 1'b1);
        chk("coll1_frame_bank", 32'(bus.frame_bank), 32'd1);
        chk("coll1_frame_ready", 32'(bus.frame_ready), 32'd1);
        send_exp(-16'sd1, 1'b0, 9'd0, 1'b0);
        chk("coll1_drop_count", 32'(bus.drop_count), 32'd10);
        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Narrow drop counter saturation.
        drive4(1024 + 15);
        chk("sat15_drop_count", 32'(bus4.drop_count), 32'd15);
        drive4(5);
        chk("sat20_drop_count", 32'(bus4.drop_count), 32'd15);
        chk("sat20_overflow", 32'(bus4.overflow), 32'd1);
        chk("sat20_frame_bank", 32'(bus4.frame_bank), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
